// File: rtl/allocator_pkg.sv
// Shared types and constants for the LSU-facing memory responder.
// The optional MEM_RESPONDER_STALL_EN macro is consumed by mem_responder, not here.
package allocator_pkg;

    localparam int DATA_W            = 32;
    localparam int MEM_WORD_OFFSET_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAS2 = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } mem_rsp_state_e;

endpackage

// File: rtl/mem_responder_ram.sv
// Word array with synchronous write and combinational read; contents are not reset.
module mem_responder_ram
    import allocator_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder (read / write / two-beat CAS) with fixed response latency.
// Define MEM_RESPONDER_STALL_EN to add LFSR-driven request backpressure and extra wait cycles.
module mem_responder
    import allocator_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    input  logic              mem_req_is_cas_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    mem_rsp_state_e    state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              init_q;
    logic              extra_q;
    logic              rsp_val_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_q;
    logic [DATA_W-1:0] cas_addr_q;
    logic [DATA_W-1:0] cas_cmp_q;

    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic              accept;
    logic              rdy_open;
    logic              cas_match;
    logic              extra_in;
    logic              gate_rdy;

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign gate_rdy = (lfsr_q[1:0] == 2'b00);
    assign extra_in = lfsr_q[2];
`else
    assign gate_rdy = 1'b0;
    assign extra_in = 1'b0;
`endif

    // The second CAS beat is resolved against the index latched from the first beat.
    assign rd_idx    = (state_q == CAS2) ? cas_addr_q[MEM_WORD_OFFSET_W +: IDX_W]
                                         : mem_req_addr_i[MEM_WORD_OFFSET_W +: IDX_W];
    assign rdy_open  = init_q && ((state_q == IDLE) || (state_q == CAS2));
    assign mem_req_rdy_o = rdy_open && !gate_rdy;
    assign accept    = mem_req_val_i && mem_req_rdy_o;
    assign cas_match = mem_req_is_cas_i && (mem_req_addr_i == cas_addr_q);
    assign ram_we    = accept &&
                       (((state_q == IDLE) && !mem_req_is_cas_i && mem_req_is_write_i) ||
                        ((state_q == CAS2) && cas_match && (ram_rdata == cas_cmp_q)));

    mem_responder_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .idx_i   (rd_idx),
        .wdata_i (mem_req_data_i),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            init_q     <= 1'b0;
            extra_q    <= 1'b0;
            rsp_val_q  <= 1'b0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            cas_addr_q <= '0;
            cas_cmp_q  <= '0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                IDLE, CAS2: begin
                    if (accept) begin
                        if ((state_q == IDLE) && mem_req_is_cas_i) begin
                            cas_addr_q <= mem_req_addr_i;
                            cas_cmp_q  <= mem_req_data_i;
                            state_q    <= CAS2;
                        end else begin
                            if (state_q == CAS2) begin
                                rsp_data_q <= ram_rdata;
                                if (!cas_match) begin
                                    err_q <= 1'b1;
                                end
                            end else if (mem_req_is_write_i) begin
                                rsp_data_q <= '0;
                            end else begin
                                rsp_data_q <= ram_rdata;
                            end
                            // The counter holds the number of WAIT cycles still to spend.
                            cnt_q   <= CNT_W'(LATENCY - 1);
                            extra_q <= extra_in;
                            if ((LATENCY == 1) && !extra_in) begin
                                state_q   <= RSP;
                                rsp_val_q <= 1'b1;
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (extra_q) begin
                        extra_q <= 1'b0;
                    end else begin
                        cnt_q     <= '0;
                        state_q   <= RSP;
                        rsp_val_q <= 1'b1;
                    end
                end
                RSP: begin
                    if (mem_rsp_rdy_i) begin
                        state_q   <= IDLE;
                        rsp_val_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rsp_val_o  = rsp_val_q;
    assign mem_rsp_data_o = rsp_data_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default parameters (MEM_DEPTH=1024, LATENCY=2).
module tb_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_req_val_i = 1'b0;
    logic        mem_req_rdy_o;
    logic        mem_req_is_write_i = 1'b0;
    logic [31:0] mem_req_addr_i = '0;
    logic [31:0] mem_req_data_i = '0;
    logic        mem_req_is_cas_i = 1'b0;
    logic        mem_rsp_val_o;
    logic        mem_rsp_rdy_i = 1'b0;
    logic [31:0] mem_rsp_data_o;
    logic        err_o;

    int tests_run = 0;
    int tests_failed = 0;

    mem_responder dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .mem_req_val_i      (mem_req_val_i),
        .mem_req_rdy_o      (mem_req_rdy_o),
        .mem_req_is_write_i (mem_req_is_write_i),
        .mem_req_addr_i     (mem_req_addr_i),
        .mem_req_data_i     (mem_req_data_i),
        .mem_req_is_cas_i   (mem_req_is_cas_i),
        .mem_rsp_val_o      (mem_rsp_val_o),
        .mem_rsp_rdy_i      (mem_rsp_rdy_i),
        .mem_rsp_data_o     (mem_rsp_data_o),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input string tag, input logic wr, input logic cas,
                             input logic [31:0] addr, input logic [31:0] data);
        int n;
        @(negedge clk_i);
        mem_req_val_i      = 1'b1;
        mem_req_is_write_i = wr;
        mem_req_is_cas_i   = cas;
        mem_req_addr_i     = addr;
        mem_req_data_i     = data;
        n = 0;
        while (!mem_req_rdy_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_rdy"}, 32'(mem_req_rdy_o), 32'd1);
        @(posedge clk_i);
        #1;
        mem_req_val_i      = 1'b0;
        mem_req_is_write_i = 1'b0;
        mem_req_is_cas_i   = 1'b0;
    endtask

    // Waits for the response, checks latency/data, holds rsp_rdy low for `hold` cycles, then handshakes.
    task automatic get_rsp(input string tag, input logic [31:0] exp, input int hold);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
            if (!mem_rsp_val_o) check({tag, "_rdy_low"}, 32'(mem_req_rdy_o), 32'd0);
        end while (!mem_rsp_val_o && n < 20);
        check({tag, "_lat"}, n, 32'd2);
        check({tag, "_val"}, 32'(mem_rsp_val_o), 32'd1);
        check({tag, "_data"}, mem_rsp_data_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check({tag, "_hold_val"}, 32'(mem_rsp_val_o), 32'd1);
            check({tag, "_hold_data"}, mem_rsp_data_o, exp);
            check({tag, "_hold_rdy"}, 32'(mem_req_rdy_o), 32'd0);
        end
        mem_rsp_rdy_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_rsp_rdy_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_val_drop"}, 32'(mem_rsp_val_o), 32'd0);
        check({tag, "_idle_rdy"}, 32'(mem_req_rdy_o), 32'd1);
    endtask

    initial begin
        // Reset values while rst_ni is low
        #12;
        check("rst_rdy", 32'(mem_req_rdy_o), 32'd0);
        check("rst_val", 32'(mem_rsp_val_o), 32'd0);
        check("rst_data", mem_rsp_data_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("init_rdy_before_edge", 32'(mem_req_rdy_o), 32'd0);
        @(negedge clk_i);
        check("init_rdy_after_edge", 32'(mem_req_rdy_o), 32'd1);

        // Write then read back
        send_beat("wr1000", 1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
        get_rsp("wr1000", 32'h0, 0);
        send_beat("rd1000", 1'b0, 1'b0, 32'h0000_1000, 32'h0);
        get_rsp("rd1000", 32'hDEAD_BEEF, 0);

        // Address wrap (0x2000 -> same word) and ignored byte offset
        send_beat("rd2000", 1'b0, 1'b0, 32'h0000_2000, 32'h0);
        get_rsp("rd2000", 32'hDEAD_BEEF, 0);
        send_beat("rd1003", 1'b0, 1'b0, 32'h0000_1003, 32'h0);
        get_rsp("rd1003", 32'hDEAD_BEEF, 0);

        // Successful CAS
        send_beat("pre20a", 1'b1, 1'b0, 32'h20, 32'd5);
        get_rsp("pre20a", 32'h0, 0);
        send_beat("cas_ok_b1", 1'b0, 1'b1, 32'h20, 32'd5);
        check("cas_ok_mid_rdy", 32'(mem_req_rdy_o), 32'd1);
        send_beat("cas_ok_b2", 1'b0, 1'b1, 32'h20, 32'd9);
        get_rsp("cas_ok", 32'd5, 0);
        send_beat("rd20_swapped", 1'b0, 1'b0, 32'h20, 32'h0);
        get_rsp("rd20_swapped", 32'd9, 0);
        check("cas_ok_err", 32'(err_o), 32'd0);

        // Failed CAS: compare mismatch, no swap
        send_beat("pre20b", 1'b1, 1'b0, 32'h20, 32'd5);
        get_rsp("pre20b", 32'h0, 0);
        send_beat("cas_miss_b1", 1'b0, 1'b1, 32'h20, 32'd7);
        send_beat("cas_miss_b2", 1'b0, 1'b1, 32'h20, 32'd9);
        get_rsp("cas_miss", 32'd5, 0);
        send_beat("rd20_kept", 1'b0, 1'b0, 32'h20, 32'h0);
        get_rsp("rd20_kept", 32'd5, 0);
        check("cas_miss_err", 32'(err_o), 32'd0);

        // CAS protocol error: second beat at a different address
        send_beat("cas_err_b1", 1'b0, 1'b1, 32'h20, 32'd5);
        send_beat("cas_err_b2", 1'b0, 1'b1, 32'h24, 32'd1);
        get_rsp("cas_err", 32'd5, 0);
        check("cas_err_set", 32'(err_o), 32'd1);
        send_beat("rd20_after_err", 1'b0, 1'b0, 32'h20, 32'h0);
        get_rsp("rd20_after_err", 32'd5, 0);

        // Response stall for 10 cycles
        send_beat("rd_stall", 1'b0, 1'b0, 32'h0000_1000, 32'h0);
        get_rsp("rd_stall", 32'hDEAD_BEEF, 10);
        check("err_sticky", 32'(err_o), 32'd1);

        // Asynchronous reset during WAIT
        send_beat("rd_abort", 1'b0, 1'b0, 32'h0000_1000, 32'h0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("abort_rdy", 32'(mem_req_rdy_o), 32'd0);
        check("abort_val", 32'(mem_rsp_val_o), 32'd0);
        check("abort_data", mem_rsp_data_o, 32'd0);
        check("abort_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rel_rdy_before_edge", 32'(mem_req_rdy_o), 32'd0);
        @(negedge clk_i);
        check("rel_rdy_after_edge", 32'(mem_req_rdy_o), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("no_rsp_after_abort", 32'(mem_rsp_val_o), 32'd0);
        end
        send_beat("rd20_post_rst", 1'b0, 1'b0, 32'h20, 32'h0);
        get_rsp("rd20_post_rst", 32'd5, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
